// File: rtl/pwm_duty_decoder_pkg.sv
// Shared definitions for the PWM duty/period decoder: FSM state encoding and
// default sizing constants.
package pwm_duty_decoder_pkg;

    localparam int unsigned CNT_W_DEFAULT       = 12;
    localparam int unsigned SYNC_STAGES_DEFAULT = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

endpackage

// File: rtl/pwm_in_conditioner.sv
// Brings the asynchronous pwm_in into the clk domain through a flop chain.
// Optional 3-sample glitch filter enabled by defining PWM_DEC_GLITCH_FILTER_EN.
module pwm_in_conditioner
    import pwm_duty_decoder_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pwm_in,
    output logic pwm_cond
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef PWM_DEC_GLITCH_FILTER_EN
    logic [1:0] hist_q;
    logic       filt_q;
    logic       agree;

    // Output follows the input only when the current and two previous samples agree.
    assign agree    = (sync_out == hist_q[0]) && (sync_out == hist_q[1]);
    assign pwm_cond = agree ? sync_out : filt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= '0;
            filt_q <= 1'b0;
        end else begin
            hist_q <= {hist_q[0], sync_out};
            filt_q <= pwm_cond;
        end
    end
`else
    assign pwm_cond = sync_out;
`endif

endmodule

// File: rtl/pwm_duty_decoder.sv
// Measures high-time and period of an asynchronous PWM input and presents each
// completed period through a valid/ready register. Filter: PWM_DEC_GLITCH_FILTER_EN.
module pwm_duty_decoder
    import pwm_duty_decoder_pkg::*;
#(
    parameter int unsigned CNT_W       = CNT_W_DEFAULT,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] duty_cnt,
    output logic [CNT_W-1:0] period_cnt,
    output logic             sample_valid,
    input  logic             sample_ready,
    output logic             overrun,
    input  logic             overrun_clr,
    output logic             stuck_hi,
    output logic             stuck_lo
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             pwm_s;
    logic             pwm_d;
    logic             rise;
    logic             fall;
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] pend_q;
    logic [CNT_W-1:0] pend_d;
    logic             stuck_hi_d;
    logic             stuck_lo_d;
    logic             sample_done;
    logic             sample_load;
    logic             sample_drop;

    pwm_in_conditioner #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_cond (
        .clk     (clk),
        .rst_n   (rst_n),
        .pwm_in  (pwm_in),
        .pwm_cond(pwm_s)
    );

    assign rise = pwm_s & ~pwm_d;
    assign fall = ~pwm_s & pwm_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_d      = pend_q;
        stuck_hi_d  = stuck_hi;
        stuck_lo_d  = stuck_lo;
        sample_done = 1'b0;

        if (rise || fall) begin
            stuck_hi_d = 1'b0;
            stuck_lo_d = 1'b0;
        end

        if (!en) begin
            state_d    = IDLE;
            cnt_d      = '0;
            stuck_hi_d = 1'b0;
            stuck_lo_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_d = HIGH;
                        cnt_d   = CNT_ONE;
                    end
                end
                HIGH: begin
                    // Counter keeps running through the falling edge so LOW ends with the full period.
                    if (fall) begin
                        state_d = LOW;
                        pend_d  = cnt_q;
                        cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
                    end else if (cnt_q == CNT_MAX) begin
                        state_d    = IDLE;
                        cnt_d      = '0;
                        pend_d     = '0;
                        stuck_hi_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                LOW: begin
                    if (rise) begin
                        sample_done = 1'b1;
                        state_d     = HIGH;
                        cnt_d       = CNT_ONE;
                    end else if (cnt_q == CNT_MAX) begin
                        state_d    = IDLE;
                        cnt_d      = '0;
                        pend_d     = '0;
                        stuck_lo_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_d    <= 1'b0;
            state_q  <= IDLE;
            cnt_q    <= '0;
            pend_q   <= '0;
            stuck_hi <= 1'b0;
            stuck_lo <= 1'b0;
        end else begin
            pwm_d    <= pwm_s;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            stuck_hi <= stuck_hi_d;
            stuck_lo <= stuck_lo_d;
        end
    end

    // A new sample may replace the held one only when the held one is consumed this cycle.
    assign sample_load = sample_done && (!sample_valid || sample_ready);
    assign sample_drop = sample_done && sample_valid && !sample_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_cnt     <= '0;
            period_cnt   <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if (sample_load) begin
                duty_cnt     <= pend_q;
                period_cnt   <= cnt_q;
                sample_valid <= 1'b1;
            end else if (sample_valid && sample_ready) begin
                sample_valid <= 1'b0;
            end

            if (sample_drop) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Self-checking bench for pwm_duty_decoder (CNT_W=8); expected samples derived
// from the generated waveform's high/low lengths.
module tb_pwm_duty_decoder;

    localparam int unsigned CNT_W = 8;
    localparam int MAXC = 255;
`ifdef PWM_DEC_GLITCH_FILTER_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 3;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic             pwm_in;
    logic [CNT_W-1:0] duty_cnt;
    logic [CNT_W-1:0] period_cnt;
    logic             sample_valid;
    logic             sample_ready;
    logic             overrun;
    logic             overrun_clr;
    logic             stuck_hi;
    logic             stuck_lo;

    int checks = 0;
    int errors = 0;
    int tk     = 0;
    int obs_d[$];
    int obs_p[$];

    always #5 clk = ~clk;

    pwm_duty_decoder #(
        .CNT_W(CNT_W),
        .SYNC_STAGES(2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .pwm_in      (pwm_in),
        .duty_cnt    (duty_cnt),
        .period_cnt  (period_cnt),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .overrun     (overrun),
        .overrun_clr (overrun_clr),
        .stuck_hi    (stuck_hi),
        .stuck_lo    (stuck_lo)
    );

    // Records a handshake just before the edge that completes it, then advances one cycle.
    task automatic tick();
        if (sample_valid === 1'b1 && sample_ready === 1'b1) begin
            obs_d.push_back(int'(duty_cnt));
            obs_p.push_back(int'(period_cnt));
        end
        @(posedge clk);
        #1;
        tk++;
    endtask

    task automatic drive(input logic lvl, input int n);
        pwm_in = lvl;
        repeat (n) tick();
    endtask

    task automatic run_to(input int target);
        while (tk < target) tick();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; en = 1'b1; pwm_in = 1'b0; sample_ready = 1'b1; overrun_clr = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        obs_d.delete();
        obs_p.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; pwm_in = 1'b0; sample_ready = 1'b1; overrun_clr = 1'b0;
        repeat (3) tick();
        checks++; if (duty_cnt !== 8'd0) begin errors++; $display("FAIL rst_duty: got %0d expected 0", duty_cnt); end
        checks++; if (period_cnt !== 8'd0) begin errors++; $display("FAIL rst_period: got %0d expected 0", period_cnt); end
        checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", sample_valid); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun: got %b expected 0", overrun); end
        checks++; if (stuck_hi !== 1'b0) begin errors++; $display("FAIL rst_stuck_hi: got %b expected 0", stuck_hi); end
        checks++; if (stuck_lo !== 1'b0) begin errors++; $display("FAIL rst_stuck_lo: got %b expected 0", stuck_lo); end
        rst_n = 1'b1;
        repeat (5) tick();
        checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL post_rst_valid: got %b expected 0", sample_valid); end
    endtask

    task automatic test_fixed_period();
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 25);
            drive(1'b0, 75);
        end
        drive(1'b1, 25);
        drive(1'b0, 20);
        checks++; if (obs_d.size() != 4) begin errors++; $display("FAIL fixed_count: got %0d expected 4", obs_d.size()); end
        for (int i = 0; i < obs_d.size(); i++) begin
            checks++; if (obs_d[i] != 25) begin errors++; $display("FAIL fixed_duty[%0d]: got %0d expected 25", i, obs_d[i]); end
            checks++; if (obs_p[i] != 100) begin errors++; $display("FAIL fixed_period[%0d]: got %0d expected 100", i, obs_p[i]); end
        end
    endtask

    task automatic test_random();
        int hi[$];
        int lo[$];
        int n;
        apply_reset();
        n = 12;
        for (int k = 0; k < n; k++) begin
            hi.push_back(int'($urandom_range(60, 3)));
            lo.push_back(int'($urandom_range(60, 3)));
            drive(1'b1, hi[k]);
            drive(1'b0, lo[k]);
        end
        drive(1'b1, 5);
        drive(1'b0, 20);
        // Each rising edge after the first closes the preceding high/low pair.
        checks++; if (obs_d.size() != n) begin errors++; $display("FAIL rand_count: got %0d expected %0d", obs_d.size(), n); end
        for (int i = 0; i < n && i < obs_d.size(); i++) begin
            checks++; if (obs_d[i] != hi[i]) begin errors++; $display("FAIL rand_duty[%0d]: got %0d expected %0d", i, obs_d[i], hi[i]); end
            checks++; if (obs_p[i] != hi[i] + lo[i]) begin errors++; $display("FAIL rand_period[%0d]: got %0d expected %0d", i, obs_p[i], hi[i] + lo[i]); end
        end
    endtask

    task automatic test_stuck();
        int t;
        apply_reset();
        drive(1'b1, 20);
        drive(1'b0, 30);
        t = tk;
        drive(1'b1, 10);
        pwm_in = 1'b0;
        run_to(t + LAT + MAXC - 1);
        checks++; if (stuck_lo !== 1'b0) begin errors++; $display("FAIL stuck_lo_early: got %b expected 0", stuck_lo); end
        run_to(t + LAT + MAXC);
        checks++; if (stuck_lo !== 1'b1) begin errors++; $display("FAIL stuck_lo_set: got %b expected 1", stuck_lo); end
        run_to(t + 10 + 300);
        checks++; if (obs_d.size() != 1) begin errors++; $display("FAIL stuck_lo_samples: got %0d expected 1", obs_d.size()); end
        if (obs_d.size() > 0) begin
            checks++; if (obs_d[0] != 20 || obs_p[0] != 50) begin errors++; $display("FAIL stuck_pre_sample: got %0d/%0d expected 20/50", obs_d[0], obs_p[0]); end
        end
        pwm_in = 1'b1;
        t = tk;
        run_to(t + LAT - 1);
        checks++; if (stuck_lo !== 1'b1) begin errors++; $display("FAIL stuck_lo_hold: got %b expected 1", stuck_lo); end
        run_to(t + LAT);
        checks++; if (stuck_lo !== 1'b0) begin errors++; $display("FAIL stuck_lo_clear: got %b expected 0", stuck_lo); end
        run_to(t + LAT + MAXC - 1);
        checks++; if (stuck_hi !== 1'b0) begin errors++; $display("FAIL stuck_hi_early: got %b expected 0", stuck_hi); end
        run_to(t + LAT + MAXC);
        checks++; if (stuck_hi !== 1'b1) begin errors++; $display("FAIL stuck_hi_set: got %b expected 1", stuck_hi); end
        run_to(t + 300);
        pwm_in = 1'b0;
        t = tk;
        run_to(t + LAT);
        checks++; if (stuck_hi !== 1'b0) begin errors++; $display("FAIL stuck_hi_clear: got %b expected 0", stuck_hi); end
        checks++; if (obs_d.size() != 1) begin errors++; $display("FAIL stuck_no_sample: got %0d expected 1", obs_d.size()); end
    endtask

    task automatic test_overrun();
        int t;
        apply_reset();
        sample_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 50);
            drive(1'b0, 150);
        end
        drive(1'b1, 50);
        drive(1'b0, 10);
        checks++; if (sample_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid: got %b expected 1", sample_valid); end
        checks++; if (duty_cnt !== 8'd50) begin errors++; $display("FAIL ovr_duty: got %0d expected 50", duty_cnt); end
        checks++; if (period_cnt !== 8'd200) begin errors++; $display("FAIL ovr_period: got %0d expected 200", period_cnt); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b expected 1", overrun); end
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clr: got %b expected 0", overrun); end
        checks++; if (sample_valid !== 1'b1 || duty_cnt !== 8'd50) begin errors++; $display("FAIL ovr_hold_after_clr: got %b/%0d expected 1/50", sample_valid, duty_cnt); end
        drive(1'b0, 139);
        pwm_in = 1'b1;
        t = tk;
        overrun_clr = 1'b1;
        run_to(t + LAT);
        overrun_clr = 1'b0;
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set_wins: got %b expected 1", overrun); end
        tick();
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b expected 1", overrun); end
        sample_ready = 1'b1;
        tick();
        checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL ovr_consume: got %b expected 0", sample_valid); end
    endtask

    task automatic test_back_to_back();
        int t;
        apply_reset();
        sample_ready = 1'b0;
        drive(1'b1, 10);
        drive(1'b0, 30);
        drive(1'b1, 15);
        drive(1'b0, 20);
        pwm_in = 1'b1;
        t = tk;
        run_to(t + LAT - 1);
        checks++; if (duty_cnt !== 8'd10 || period_cnt !== 8'd40 || sample_valid !== 1'b1) begin
            errors++; $display("FAIL b2b_before: got %0d/%0d v%b expected 10/40 v1", duty_cnt, period_cnt, sample_valid); end
        sample_ready = 1'b1;
        tick();
        sample_ready = 1'b0;
        checks++; if (duty_cnt !== 8'd15 || period_cnt !== 8'd35) begin errors++; $display("FAIL b2b_values: got %0d/%0d expected 15/35", duty_cnt, period_cnt); end
        checks++; if (sample_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b expected 1", sample_valid); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun: got %b expected 0", overrun); end
        tick();
        checks++; if (sample_valid !== 1'b1 || duty_cnt !== 8'd15) begin errors++; $display("FAIL b2b_hold: got %b/%0d expected 1/15", sample_valid, duty_cnt); end
    endtask

    task automatic test_glitch();
        int exp_d[$];
        int exp_p[$];
`ifdef PWM_DEC_GLITCH_FILTER_EN
        exp_d = '{20, 20};
        exp_p = '{81, 49};
`else
        exp_d = '{20, 1, 20};
        exp_p = '{50, 31, 49};
`endif
        apply_reset();
        drive(1'b1, 20); drive(1'b0, 30); drive(1'b1, 1); drive(1'b0, 30);
        drive(1'b1, 20); drive(1'b0, 29); drive(1'b1, 5); drive(1'b0, 20);
        checks++; if (obs_d.size() != exp_d.size()) begin errors++; $display("FAIL glitch_count: got %0d expected %0d", obs_d.size(), exp_d.size()); end
        for (int i = 0; i < exp_d.size() && i < obs_d.size(); i++) begin
            checks++; if (obs_d[i] != exp_d[i] || obs_p[i] != exp_p[i]) begin
                errors++; $display("FAIL glitch_sample[%0d]: got %0d/%0d expected %0d/%0d", i, obs_d[i], obs_p[i], exp_d[i], exp_p[i]); end
        end
    endtask

    task automatic test_enable();
        apply_reset();
        sample_ready = 1'b0;
        drive(1'b1, 10); drive(1'b0, 20); drive(1'b1, 10); drive(1'b0, 20);
        drive(1'b1, 10); drive(1'b0, 280);
        checks++; if (stuck_lo !== 1'b1) begin errors++; $display("FAIL en_pre_stuck: got %b expected 1", stuck_lo); end
        en = 1'b0;
        repeat (2) tick();
        checks++; if (stuck_lo !== 1'b0) begin errors++; $display("FAIL en_stuck_clr: got %b expected 0", stuck_lo); end
        checks++; if (sample_valid !== 1'b1 || duty_cnt !== 8'd10 || period_cnt !== 8'd30) begin
            errors++; $display("FAIL en_held: got v%b %0d/%0d expected v1 10/30", sample_valid, duty_cnt, period_cnt); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL en_overrun_kept: got %b expected 1", overrun); end
        en = 1'b1;
        sample_ready = 1'b1;
        tick();
        obs_d.delete();
        obs_p.delete();
        drive(1'b1, 10); drive(1'b0, 10); drive(1'b1, 5); drive(1'b0, 10);
        checks++; if (obs_d.size() != 1) begin errors++; $display("FAIL en_restart_count: got %0d expected 1", obs_d.size()); end
        if (obs_d.size() > 0) begin
            checks++; if (obs_d[0] != 10 || obs_p[0] != 20) begin errors++; $display("FAIL en_restart_sample: got %0d/%0d expected 10/20", obs_d[0], obs_p[0]); end
        end
    endtask

    task automatic test_reset_mid();
        int t;
        apply_reset();
        sample_ready = 1'b0;
        drive(1'b1, 10); drive(1'b0, 20); drive(1'b1, 10); drive(1'b0, 20); drive(1'b1, 30);
        checks++; if (sample_valid !== 1'b1 || overrun !== 1'b1) begin errors++; $display("FAIL mid_pre: got v%b o%b expected v1 o1", sample_valid, overrun); end
        rst_n = 1'b0;
        #1;
        checks++; if (duty_cnt !== 8'd0 || period_cnt !== 8'd0) begin errors++; $display("FAIL mid_rst_counts: got %0d/%0d expected 0/0", duty_cnt, period_cnt); end
        checks++; if (sample_valid !== 1'b0 || overrun !== 1'b0 || stuck_hi !== 1'b0 || stuck_lo !== 1'b0) begin
            errors++; $display("FAIL mid_rst_flags: got v%b o%b h%b l%b expected all 0", sample_valid, overrun, stuck_hi, stuck_lo); end
        pwm_in = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        sample_ready = 1'b1;
        obs_d.delete();
        obs_p.delete();
        drive(1'b0, 5); drive(1'b1, 30); drive(1'b0, 50);
        pwm_in = 1'b1;
        t = tk;
        run_to(t + LAT - 1);
        checks++; if (sample_valid !== 1'b0 || obs_d.size() != 0) begin errors++; $display("FAIL mid_first_rise: got v%b n%0d expected v0 n0", sample_valid, obs_d.size()); end
        run_to(t + LAT);
        checks++; if (sample_valid !== 1'b1 || duty_cnt !== 8'd30 || period_cnt !== 8'd80) begin
            errors++; $display("FAIL mid_first_sample: got v%b %0d/%0d expected v1 30/80", sample_valid, duty_cnt, period_cnt); end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; pwm_in = 1'b0; sample_ready = 1'b1; overrun_clr = 1'b0;
        test_reset();
        test_fixed_period();
        test_random();
        test_stuck();
        test_overrun();
        test_back_to_back();
        test_glitch();
        test_enable();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
